bin_a_bcd_serie: RTL and testbench

- Sequential binary-to-BCD converter using the shift-and-add-3 (double-dabble) method, one bit per clock.
- Sits directly downstream of the unsigned arithmetic stages: the 8-bit 9*X product and the zero-extended 5-bit adder sum.
- Drives per-digit BCD values to the display/decoder stage of the lab.
- Start/done handshake; holds the last result stable between conversions.

---
 rtl/bin_a_bcd_serie.sv | 120 ++++++++++++
 tb/tb_bin_a_bcd_serie.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/bin_a_bcd_serie.sv
// Serial binary-to-BCD converter (shift-and-add-3), one bit per clock.
// Start/done handshake; result registers hold between conversions.
module bin_a_bcd_serie #(
    parameter int WIDTH  = 8,
    parameter int DIGITS = 3
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [WIDTH-1:0]      bin,
    output logic                  busy,
    output logic                  done,
    output logic [4*DIGITS-1:0]   bcd,
    output logic                  overflow
);

    localparam int CW = $clog2(WIDTH + 1);
    localparam int BW = 4 * DIGITS;

    typedef enum logic [1:0] {
        IDLE,
        CONV,
        DONE
    } state_t;

    state_t         state;
    state_t         stateNext;
    logic [WIDTH-1:0] shiftReg;
    logic [BW-1:0]  bcdScr;
    logic           ovfScr;
    logic [CW-1:0]  cnt;

    logic [BW-1:0]    adjScr;
    logic [BW-1:0]    nextScr;
    logic [WIDTH-1:0] nextShift;
    logic             shiftOut;
    logic [CW-1:0]    nextCnt;
    logic             lastBit;

    // Add-3 correction per digit, then one-bit shift of {scratch, operand}
    always_comb begin
        adjScr = bcdScr;
        for (int i = 0; i < DIGITS; i++) begin
            if (bcdScr[4*i +: 4] >= 4'd5) begin
                adjScr[4*i +: 4] = bcdScr[4*i +: 4] + 4'd3;
            end
        end
        {shiftOut, nextScr, nextShift} = {adjScr, shiftReg, 1'b0};
        nextCnt = cnt + 1'b1;
        lastBit = (nextCnt == CW'(WIDTH));
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= stateNext;
        end
    end

    // Next-state logic
    always_comb begin
        stateNext = state;
        unique case (state)
            IDLE:    if (start) stateNext = CONV;
            CONV:    if (lastBit) stateNext = DONE;
            DONE:    stateNext = IDLE;
            default: stateNext = IDLE;
        endcase
    end

    // Handshake outputs decoded from state
    always_comb begin
        busy = 1'b0;
        done = 1'b0;
        unique case (state)
            IDLE:    ;
            CONV:    busy = 1'b1;
            DONE:    done = 1'b1;
            default: ;
        endcase
    end

    // Operand capture, conversion datapath and result registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shiftReg <= '0;
            bcdScr   <= '0;
            ovfScr   <= 1'b0;
            cnt      <= '0;
            bcd      <= '0;
            overflow <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (start) begin
                        shiftReg <= bin;
                        bcdScr   <= '0;
                        ovfScr   <= 1'b0;
                        cnt      <= '0;
                    end
                end
                CONV: begin
                    shiftReg <= nextShift;
                    bcdScr   <= nextScr;
                    ovfScr   <= ovfScr | shiftOut;
                    cnt      <= nextCnt;
                    if (lastBit) begin
                        bcd      <= nextScr;
                        overflow <= ovfScr | shiftOut;
                    end
                end
                DONE:    ;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_bin_a_bcd_serie.sv
// Directed bench for bin_a_bcd_serie (3-digit and 2-digit instances).
// Table-driven vectors plus hand-written multi-cycle sequences.
module tb_bin_a_bcd_serie;

    logic        clk;
    logic        rst_n;
    logic        start3;
    logic [7:0]  bin3;
    logic        busy3;
    logic        done3;
    logic [11:0] bcd3;
    logic        ovf3;
    logic        start2;
    logic [7:0]  bin2;
    logic        busy2;
    logic        done2;
    logic [7:0]  bcd2;
    logic        ovf2;

    int checks;
    int errors;

    bit          selDut;
    logic        curBusy;
    logic        curDone;
    logic [11:0] curBcd;
    logic        curOvf;

    typedef struct {
        logic [7:0]  b;
        logic [11:0] e;
    } vec_t;

    vec_t       vecs[22];
    logic [7:0] bvals[30];

    bin_a_bcd_serie #(.WIDTH(8), .DIGITS(3)) dut3 (
        .clk(clk), .rst_n(rst_n), .start(start3), .bin(bin3),
        .busy(busy3), .done(done3), .bcd(bcd3), .overflow(ovf3)
    );

    bin_a_bcd_serie #(.WIDTH(8), .DIGITS(2)) dut2 (
        .clk(clk), .rst_n(rst_n), .start(start2), .bin(bin2),
        .busy(busy2), .done(done2), .bcd(bcd2), .overflow(ovf2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always_comb begin
        curBusy = selDut ? busy2 : busy3;
        curDone = selDut ? done2 : done3;
        curBcd  = selDut ? {4'h0, bcd2} : bcd3;
        curOvf  = selDut ? ovf2 : ovf3;
    end

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    function automatic logic [11:0] toBcd(input logic [7:0] v);
        int n;
        n = int'(v);
        return {4'(n / 100), 4'((n / 10) % 10), 4'(n % 10)};
    endfunction

    task automatic drive(input bit sel, input logic s, input logic [7:0] b);
        if (sel) begin
            start2 = s;
            bin2   = b;
        end else begin
            start3 = s;
            bin3   = b;
        end
    endtask

    // Caller is at a negedge with the selected DUT idle.
    task automatic convert(input bit sel, input logic [7:0] b,
                           input logic [11:0] expB, input logic expO,
                           input bit pulseMid, input string nm);
        logic [11:0] prevBcd;
        int lat;
        selDut = sel;
        #1;
        prevBcd = curBcd;
        drive(sel, 1'b1, b);
        @(negedge clk);
        drive(sel, 1'b0, ~b);
        #1;
        chk({nm, " busy"}, 32'(curBusy), 32'd1);
        chk({nm, " hold"}, 32'(curBcd), 32'(prevBcd));
        lat = 0;
        for (int i = 1; i <= 20; i++) begin
            if (pulseMid && i == 3) drive(sel, 1'b1, 8'd1);
            else drive(sel, 1'b0, ~b);
            @(negedge clk);
            #1;
            if (curDone) begin
                lat = i;
                break;
            end
        end
        drive(sel, 1'b0, 8'd0);
        chk({nm, " latency"}, 32'(lat), 32'd8);
        chk({nm, " bcd"}, 32'(curBcd), 32'(expB));
        chk({nm, " ovf"}, 32'(curOvf), 32'(expO));
        @(negedge clk);
        #1;
        chk({nm, " idle"}, 32'({curBusy, curDone}), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        checks = 0;
        errors = 0;
        selDut = 1'b0;
        rst_n  = 1'b0;
        start3 = 1'b0;
        bin3   = 8'd0;
        start2 = 1'b0;
        bin2   = 8'd0;

        vecs[0] = '{8'd135, 12'h135};
        vecs[1] = '{8'd0,   12'h000};
        vecs[2] = '{8'd9,   12'h009};
        vecs[3] = '{8'd99,  12'h099};
        vecs[4] = '{8'd255, 12'h255};
        vecs[5] = '{8'd31,  12'h031};
        vecs[6]  = '{8'd0,   12'h000};
        vecs[7]  = '{8'd9,   12'h009};
        vecs[8]  = '{8'd18,  12'h018};
        vecs[9]  = '{8'd27,  12'h027};
        vecs[10] = '{8'd36,  12'h036};
        vecs[11] = '{8'd45,  12'h045};
        vecs[12] = '{8'd54,  12'h054};
        vecs[13] = '{8'd63,  12'h063};
        vecs[14] = '{8'd72,  12'h072};
        vecs[15] = '{8'd81,  12'h081};
        vecs[16] = '{8'd90,  12'h090};
        vecs[17] = '{8'd99,  12'h099};
        vecs[18] = '{8'd108, 12'h108};
        vecs[19] = '{8'd117, 12'h117};
        vecs[20] = '{8'd126, 12'h126};
        vecs[21] = '{8'd135, 12'h135};

        for (int t = 0; t < 30; t++) bvals[t] = 8'(t * 37 + 11);

        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        #1;
        chk("rst bcd3", 32'(bcd3), 32'h000);
        chk("rst busy3", 32'(busy3), 32'd0);
        chk("rst done3", 32'(done3), 32'd0);
        chk("rst ovf3", 32'(ovf3), 32'd0);
        chk("rst bcd2", 32'(bcd2), 32'h00);
        @(negedge clk);

        for (int i = 0; i < 22; i++) begin
            convert(1'b0, vecs[i].b, vecs[i].e, 1'b0, 1'b0,
                    $sformatf("vec%0d", i));
        end

        convert(1'b0, 8'd135, 12'h135, 1'b0, 1'b1, "ignore-start");
        @(negedge clk);
        #1;
        chk("no queued conv", 32'(busy3), 32'd0);

        // Back-to-back: start held high, bin changing every cycle
        begin
            int nDone;
            nDone = 0;
            for (int t = 0; t < 30; t++) begin
                bin3   = bvals[t];
                start3 = 1'b1;
                @(negedge clk);
                #1;
                if (done3) nDone++;
                if (t % 10 == 8) begin
                    chk($sformatf("b2b done t%0d", t), 32'(done3), 32'd1);
                    chk($sformatf("b2b bcd t%0d", t), 32'(bcd3),
                        32'(toBcd(bvals[t-8])));
                end
            end
            start3 = 1'b0;
            chk("b2b count", 32'(nDone), 32'd3);
            @(negedge clk);
        end

        // Reset in the 4th CONV cycle of bin=200
        begin
            int nDone;
            nDone = 0;
            start3 = 1'b1;
            bin3   = 8'd200;
            @(negedge clk);
            start3 = 1'b0;
            repeat (3) @(negedge clk);
            #2;
            rst_n = 1'b0;
            #1;
            chk("abort busy", 32'(busy3), 32'd0);
            chk("abort bcd", 32'(bcd3), 32'h000);
            chk("abort ovf", 32'(ovf3), 32'd0);
            for (int i = 0; i < 3; i++) begin
                @(negedge clk);
                if (done3) nDone++;
            end
            rst_n = 1'b1;
            for (int i = 0; i < 10; i++) begin
                @(negedge clk);
                #1;
                if (done3) nDone++;
            end
            chk("abort no done", 32'(nDone), 32'd0);
            convert(1'b0, 8'd42, 12'h042, 1'b0, 1'b0, "after-reset");
        end

        convert(1'b1, 8'd135, 12'h035, 1'b1, 1'b0, "d2 135");
        convert(1'b1, 8'd99, 12'h099, 1'b0, 1'b0, "d2 99");
        convert(1'b1, 8'd255, 12'h055, 1'b1, 1'b0, "d2 255");

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
